pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_slot.sv | 51 +++++
 rtl/pipe_stage_reg.sv | 174 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Widest supported control field; slots slice the low CTRL_W bits.
  localparam int CTRL_MAX_W = 64;
  localparam logic [CTRL_MAX_W-1:0] CTRL_BUBBLE = 64'd0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag, control, payload and destination.
// Clear drops the slot and zeroes control but keeps payload and destination.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DEST_W-1:0] dest_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DEST_W-1:0] dest_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic [DEST_W-1:0] dest_q;

  // Entry storage; clear outranks load so a flush always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE[CTRL_W-1:0];
      data_q  <= {DATA_W{1'b0}};
      dest_q  <= {DEST_W{1'b0}};
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE[CTRL_W-1:0];
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
      dest_q  <= dest_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
  assign dest_o  = dest_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush, optional skid entry,
// forwarding tap and a saturating output-transfer counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int DEST_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  xfer_cnt
);

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic              fwd_valid_q;
  logic [CNT_W-1:0]  xfer_cnt_q;

  logic              in_xfer_s, out_xfer_s;
  logic              main_load_s, main_clear_s, main_from_skid_s;
  logic              skid_load_s, skid_clear_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic [DATA_W-1:0] main_data_s;
  logic [DEST_W-1:0] main_dest_s;
  logic              skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [DEST_W-1:0] skid_dest_s;

  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid & out_ready;

  // Slot movement and next state; flush empties the stage regardless of handshake.
  always_comb begin
    state_d          = state_q;
    main_load_s      = 1'b0;
    main_clear_s     = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clear_s     = 1'b0;
    if (flush) begin
      state_d      = ST_EMPTY;
      main_clear_s = 1'b1;
      skid_clear_s = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_load_s = 1'b1;
            state_d     = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            main_load_s = 1'b1;
          end else if (in_xfer_s) begin
            skid_load_s = 1'b1;
            state_d     = ST_TWO;
          end else if (out_xfer_s) begin
            main_clear_s = 1'b1;
            state_d      = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_xfer_s && skid_valid_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clear_s     = 1'b1;
            state_d          = ST_ONE;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end
      endcase
    end
  end

  assign main_ctrl_s = main_from_skid_s ? skid_ctrl_s : in_ctrl;
  assign main_data_s = main_from_skid_s ? skid_data_s : in_data;
  assign main_dest_s = main_from_skid_s ? skid_dest_s : in_dest;

  // State, registered ready, forwarding flag and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      fwd_valid_q <= 1'b0;
      xfer_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      if (main_clear_s) begin
        fwd_valid_q <= 1'b0;
      end else if (main_load_s) begin
        fwd_valid_q <= (main_ctrl_s != CTRL_BUBBLE[CTRL_W-1:0]);
      end
      if (out_xfer_s && (xfer_cnt_q != {CNT_W{1'b1}})) begin
        xfer_cnt_q <= xfer_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEST_W(DEST_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load_s),
    .clear_i (main_clear_s),
    .ctrl_i  (main_ctrl_s),
    .data_i  (main_data_s),
    .dest_i  (main_dest_s),
    .valid_o (out_valid),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data),
    .dest_o  (out_dest)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEST_W(DEST_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .dest_i  (in_dest),
        .valid_o (skid_valid_s),
        .ctrl_o  (skid_ctrl_s),
        .data_o  (skid_data_s),
        .dest_o  (skid_dest_s)
      );
      assign in_ready = in_ready_q & ~rst;
    end else begin : g_noskid
      assign skid_valid_s = 1'b0;
      assign skid_ctrl_s  = {CTRL_W{1'b0}};
      assign skid_data_s  = {DATA_W{1'b0}};
      assign skid_dest_s  = {DEST_W{1'b0}};
      // Without a skid entry, ready must see this cycle's downstream accept.
      assign in_ready     = ~rst & (~out_valid | out_ready);
    end
  endgenerate

  assign fwd_valid = fwd_valid_q;
  assign fwd_dest  = out_dest;
  assign fwd_data  = out_data;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (SKID=1, CNT_W=4): reset, streaming,
// a vector table for stall/skid/flush/bubble, then counter saturation.
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int RW = 5;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, flush, out_valid, out_ready, fwd_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data, fwd_data;
  logic [RW-1:0] in_dest, out_dest, fwd_dest;
  logic [NW-1:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic [RW-1:0] ir;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [RW-1:0] er;
    logic          eir;
    logic          efwd;
    logic [NW-1:0] ecnt;
  } vec_t;

  vec_t vecs[14];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEST_W(RW), .SKID(1), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .fwd_valid (fwd_valid),
    .fwd_dest  (fwd_dest),
    .fwd_data  (fwd_data),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                              input logic [RW-1:0] ir, input logic ordy, input logic fl,
                              input logic ev, input logic [CW-1:0] ec, input logic [DW-1:0] ed,
                              input logic [RW-1:0] er, input logic eir, input logic efwd,
                              input logic [NW-1:0] ecnt);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ir = ir; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ec = ec; v.ed = ed; v.er = er; v.eir = eir; v.efwd = efwd; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    // Stall/skid, flush in TWO, flush with accepted input, bubble ctrl, zero-ctrl slot.
    vecs[0]  = mk(1'b1, 8'h03, 64'h1111, 5'd1, 1'b0, 1'b0, 1'b1, 8'h03, 64'h1111, 5'd1, 1'b1, 1'b1, 4'd10);
    vecs[1]  = mk(1'b1, 8'h05, 64'h2222, 5'd2, 1'b0, 1'b0, 1'b1, 8'h03, 64'h1111, 5'd1, 1'b0, 1'b1, 4'd10);
    vecs[2]  = mk(1'b1, 8'h06, 64'h3333, 5'd3, 1'b0, 1'b0, 1'b1, 8'h03, 64'h1111, 5'd1, 1'b0, 1'b1, 4'd10);
    vecs[3]  = mk(1'b1, 8'h06, 64'h3333, 5'd3, 1'b1, 1'b0, 1'b1, 8'h05, 64'h2222, 5'd2, 1'b1, 1'b1, 4'd11);
    vecs[4]  = mk(1'b1, 8'h06, 64'h3333, 5'd3, 1'b1, 1'b0, 1'b1, 8'h06, 64'h3333, 5'd3, 1'b1, 1'b1, 4'd12);
    vecs[5]  = mk(1'b0, 8'h06, 64'h3333, 5'd3, 1'b1, 1'b0, 1'b0, 8'h00, 64'h3333, 5'd3, 1'b1, 1'b0, 4'd13);
    vecs[6]  = mk(1'b1, 8'h07, 64'h4444, 5'd4, 1'b0, 1'b0, 1'b1, 8'h07, 64'h4444, 5'd4, 1'b1, 1'b1, 4'd13);
    vecs[7]  = mk(1'b1, 8'h09, 64'h5555, 5'd5, 1'b0, 1'b0, 1'b1, 8'h07, 64'h4444, 5'd4, 1'b0, 1'b1, 4'd13);
    vecs[8]  = mk(1'b1, 8'h0B, 64'h6666, 5'd6, 1'b0, 1'b1, 1'b0, 8'h00, 64'h4444, 5'd4, 1'b1, 1'b0, 4'd13);
    vecs[9]  = mk(1'b1, 8'h0A, 64'h7777, 5'd7, 1'b1, 1'b0, 1'b1, 8'h0A, 64'h7777, 5'd7, 1'b1, 1'b1, 4'd13);
    vecs[10] = mk(1'b1, 8'h0C, 64'h8888, 5'd8, 1'b1, 1'b1, 1'b0, 8'h00, 64'h7777, 5'd7, 1'b1, 1'b0, 4'd14);
    vecs[11] = mk(1'b0, 8'hFF, 64'hFFFF, 5'd9, 1'b1, 1'b0, 1'b0, 8'h00, 64'h7777, 5'd7, 1'b1, 1'b0, 4'd14);
    vecs[12] = mk(1'b1, 8'h00, 64'h9999, 5'd10, 1'b0, 1'b0, 1'b1, 8'h00, 64'h9999, 5'd10, 1'b1, 1'b0, 4'd14);
    vecs[13] = mk(1'b0, 8'h00, 64'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 64'h9999, 5'd10, 1'b1, 1'b0, 4'd15);

    rst = 1'b1; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 64'hDEAD; in_dest = 5'd31;
    flush = 1'b0; out_ready = 1'b1;

    // Reset held three cycles with a valid input offered.
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    end
    check("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_dest", {59'd0, out_dest}, 64'd0);
    check("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    check("rst_xfer_cnt", {60'd0, xfer_cnt}, 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming: ten slots, one per cycle, each visible one edge after acceptance.
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_ctrl = 8'h01; in_data = 64'(i); in_dest = 5'(i);
      cyc();
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_data", out_data, 64'(i));
      check("stream_dest", {59'd0, out_dest}, 64'(i));
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    cyc();
    check("stream_drain_valid", {63'd0, out_valid}, 64'd0);
    check("stream_drain_data", out_data, 64'd10);
    check("stream_cnt", {60'd0, xfer_cnt}, 64'd10);

    // Table: one cycle per row, registered outputs compared after the edge.
    for (int k = 0; k < 14; k++) begin
      in_valid = vecs[k].iv; in_ctrl = vecs[k].ic; in_data = vecs[k].id;
      in_dest = vecs[k].ir; out_ready = vecs[k].ordy; flush = vecs[k].fl;
      cyc();
      if (out_valid !== vecs[k].ev || out_ctrl !== vecs[k].ec || out_data !== vecs[k].ed ||
          out_dest !== vecs[k].er || in_ready !== vecs[k].eir || fwd_valid !== vecs[k].efwd ||
          xfer_cnt !== vecs[k].ecnt || fwd_data !== vecs[k].ed || fwd_dest !== vecs[k].er) begin
        bad++;
        $display("FAIL vec%0d: got v=%b c=%h d=%h r=%0d ir=%b fwd=%b cnt=%0d expected v=%b c=%h d=%h r=%0d ir=%b fwd=%b cnt=%0d",
                 k, out_valid, out_ctrl, out_data, out_dest, in_ready, fwd_valid, xfer_cnt,
                 vecs[k].ev, vecs[k].ec, vecs[k].ed, vecs[k].er, vecs[k].eir, vecs[k].efwd, vecs[k].ecnt);
      end
      total++;
    end
    flush = 1'b0;

    // Saturation: twenty more transfers must leave the counter pinned at its maximum.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_ctrl = 8'h02; in_data = 64'(100 + i); in_dest = 5'd1; out_ready = 1'b1;
      cyc();
    end
    check("sat_last_data", out_data, 64'd119);
    in_valid = 1'b0;
    cyc();
    check("sat_cnt", {60'd0, xfer_cnt}, 64'd15);
    check("sat_drain_valid", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
